// File: rtl/mvb_rr_merge.sv
// mvb_rr_merge: round-robin merge of RX_PORTS MVB input streams onto one MVB
// output stream. Whole words move at a time. A grant can be held for a burst of
// up to MAX_BURST words while the locked port keeps its source ready high.
// Optional feature macro: MVB_RR_MERGE_SEL_OUT_EN. When it is defined, each
// output item is {sel, data}, and sel is the source port index.
//
// state  | meaning
// IDLE   | no lock; the next grant is the round-robin choice starting at rr_ptr
// LOCKED | lock_port keeps the grant while ready and burst_cnt < MAX_BURST
module mvb_rr_merge #(
   parameter int RX_PORTS   = 4,
   parameter int ITEMS      = 4,
   parameter int ITEM_WIDTH = 32,
   parameter int MAX_BURST  = 4,
   localparam int SEL_WIDTH = $clog2(RX_PORTS),
`ifdef MVB_RR_MERGE_SEL_OUT_EN
   localparam int TX_ITEM_WIDTH = ITEM_WIDTH + SEL_WIDTH
`else
   localparam int TX_ITEM_WIDTH = ITEM_WIDTH
`endif
) (
   input  logic                                 CLK,
   input  logic                                 RESET,
   input  logic [RX_PORTS*ITEMS*ITEM_WIDTH-1:0] RX_DATA,
   input  logic [RX_PORTS*ITEMS-1:0]            RX_VLD,
   input  logic [RX_PORTS-1:0]                  RX_SRC_RDY,
   output logic [RX_PORTS-1:0]                  RX_DST_RDY,
   output logic [ITEMS*TX_ITEM_WIDTH-1:0]       TX_DATA,
   output logic [ITEMS-1:0]                     TX_VLD,
   output logic                                 TX_SRC_RDY,
   input  logic                                 TX_DST_RDY
);

   localparam int WORD_W = ITEMS*ITEM_WIDTH;
   localparam int CNT_W  = $clog2(MAX_BURST+1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                       state_q, state_d;
   logic [SEL_WIDTH-1:0]         lock_port_q, lock_port_d;
   logic [SEL_WIDTH-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]             burst_cnt_q, burst_cnt_d, cnt_next;
   logic                         tx_src_rdy_q, tx_src_rdy_d;
   logic [ITEMS-1:0]             tx_vld_q, tx_vld_d;
   logic [ITEMS*TX_ITEM_WIDTH-1:0] tx_data_q, tx_data_d;

   logic                         load, lock_hold, rr_valid, grant_any, accept;
   logic [SEL_WIDTH-1:0]         rr_port, grant_port, cand;
   logic [ITEMS-1:0]             word_vld;
   logic [WORD_W-1:0]            word_data;

   // The register can take a new word when it is empty or is being drained.
   assign load      = !tx_src_rdy_q || TX_DST_RDY;
   assign lock_hold = (state_q == LOCKED) && RX_SRC_RDY[lock_port_q]
                      && (burst_cnt_q < CNT_W'(MAX_BURST));
   assign grant_any  = lock_hold || rr_valid;
   assign grant_port = lock_hold ? lock_port_q : rr_port;
   assign accept     = !RESET && load && grant_any;

   // Cyclic search for the first ready port, starting at rr_ptr.
   always_comb begin
      rr_valid = 1'b0;
      rr_port  = '0;
      cand     = '0;
      for (int k = 0; k < RX_PORTS; k++) begin
         cand = SEL_WIDTH'((int'(rr_ptr_q) + k) % RX_PORTS);
         if (!rr_valid && RX_SRC_RDY[cand]) begin
            rr_valid = 1'b1;
            rr_port  = cand;
         end
      end
   end

   // One-hot accept for the granted port. This is never asserted during backpressure or reset.
   always_comb begin
      RX_DST_RDY = '0;
      if (accept) RX_DST_RDY[grant_port] = 1'b1;
   end

   // Arbiter next state. A lock that is no longer ready is released in the same
   // cycle as the new round-robin pick, so no bubble is inserted.
   always_comb begin
      state_d     = state_q;
      lock_port_d = lock_port_q;
      burst_cnt_d = burst_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_next    = lock_hold ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
      if (accept) begin
         burst_cnt_d = cnt_next;
         state_d     = (cnt_next == CNT_W'(MAX_BURST)) ? IDLE : LOCKED;
         if (!lock_hold) begin
            lock_port_d = grant_port;
            rr_ptr_d    = SEL_WIDTH'((int'(grant_port) + 1) % RX_PORTS);
         end
      end else if (load) begin
         state_d     = IDLE;
         burst_cnt_d = '0;
      end
   end

   // Arbiter state register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         lock_port_q <= '0;
         burst_cnt_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         lock_port_q <= lock_port_d;
         burst_cnt_q <= burst_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   // Output stage next value. An empty word is consumed but not loaded.
   always_comb begin
      word_vld     = RX_VLD[grant_port*ITEMS +: ITEMS];
      word_data    = RX_DATA[grant_port*WORD_W +: WORD_W];
      tx_src_rdy_d = tx_src_rdy_q;
      tx_vld_d     = tx_vld_q;
      tx_data_d    = tx_data_q;
      if (load) begin
         tx_src_rdy_d = accept && (|word_vld);
         tx_vld_d     = '0;
         if (accept && (|word_vld)) begin
            tx_vld_d = word_vld;
`ifdef MVB_RR_MERGE_SEL_OUT_EN
            for (int i = 0; i < ITEMS; i++) begin
               tx_data_d[i*TX_ITEM_WIDTH +: TX_ITEM_WIDTH] =
                  {grant_port, word_data[i*ITEM_WIDTH +: ITEM_WIDTH]};
            end
`else
            tx_data_d = word_data;
`endif
         end
      end
   end

   // Output register. Reset discards any held word.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tx_src_rdy_q <= 1'b0;
         tx_vld_q     <= '0;
         tx_data_q    <= '0;
      end else begin
         tx_src_rdy_q <= tx_src_rdy_d;
         tx_vld_q     <= tx_vld_d;
         tx_data_q    <= tx_data_d;
      end
   end

   assign TX_SRC_RDY = tx_src_rdy_q;
   assign TX_VLD     = tx_vld_q;
   assign TX_DATA    = tx_data_q;

endmodule
